// File: rtl/pci_initiator.sv
// pci_initiator: PCI bus master turning one local request into a memory read/write burst.
// Define PCI_INIT_PARITY_EN to build PAR generation; otherwise PAR stays Z.
module pci_initiator #(
    parameter int MAX_BURST      = 4,
    parameter int DEVSEL_TIMEOUT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [3:0]  cmd_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  len_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wbe_i,
    output logic        wdata_ack_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [2:0]  xfer_cnt_o,
    output logic        frame_o,
    output logic        irdy_o,
    inout  wire  [31:0] ad_io,
    output logic [3:0]  cbe_o,
    inout  wire         par_io,
    input  logic        devsel_i,
    input  logic        trdy_i,
    input  logic        stop_i
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_END, S_PARK} state_e;
    state_e state_q, state_d;
    logic [31:0] addr_q, rdata_q, ad_q, ad_d;
    logic [3:0]  cmd_q, cbe_q, cbe_d;
    logic [2:0]  rem_q, cnt_q, dev_cnt_q, len_c;
    logic [1:0]  status_q, st_end;
    logic        busy_q, done_q, rvalid_q, wack_q, dev_seen_q;
    logic        frame_q, frame_d, frame_oe_q, frame_oe_d, irdy_q, irdy_d, irdy_oe_q, irdy_oe_d;
    logic        ad_oe_q, ad_oe_d, cbe_oe_q, cbe_oe_d;
    logic        wr, last, xfer, stop_hit, abort;
    assign len_c    = (len_i == 3'd0) ? 3'd1 : (int'(len_i) > MAX_BURST) ? 3'(MAX_BURST) : len_i;
    assign wr       = cmd_q[0];
    assign last     = rem_q == 3'd1;
    assign xfer     = state_q == S_DATA && !trdy_i;
    assign stop_hit = state_q == S_DATA && !stop_i;
    assign abort    = state_q == S_DATA && devsel_i && !dev_seen_q && dev_cnt_q == 3'(DEVSEL_TIMEOUT - 1);
    assign st_end   = stop_hit ? (xfer ? (last ? 2'b00 : 2'b10) : (cnt_q == 3'd0 ? 2'b01 : 2'b10))
                               : (xfer ? 2'b00 : 2'b11);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_i ? S_ADDR : S_IDLE;
            S_ADDR:  state_d = S_DATA;
            S_DATA:  state_d = ((xfer && last) || stop_hit || abort) ? S_END : S_DATA;
            S_END:   state_d = S_PARK;
            default: state_d = S_IDLE;
        endcase
    end
    // bus values for the coming cycle; launched on the next negedge
    always_comb begin
        frame_oe_d = state_q inside {S_ADDR, S_DATA, S_END};
        frame_d    = state_q != S_ADDR && (state_q != S_DATA || last);
        irdy_oe_d  = frame_oe_d;
        irdy_d     = state_q != S_DATA;
        ad_oe_d    = state_q == S_ADDR || (state_q == S_DATA && wr);
        ad_d       = state_q == S_ADDR ? addr_q : wdata_i;
        cbe_oe_d   = state_q inside {S_ADDR, S_DATA};
        cbe_d      = state_q == S_ADDR ? cmd_q : wbe_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0; cmd_q <= '0; rem_q <= '0; cnt_q <= '0; status_q <= '0; rdata_q <= '0;
            busy_q <= 1'b0; done_q <= 1'b0; rvalid_q <= 1'b0; wack_q <= 1'b0;
            dev_cnt_q <= '0; dev_seen_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            if (state_q == S_IDLE && start_i) begin
                busy_q <= 1'b1; addr_q <= addr_i; cmd_q <= cmd_i; rem_q <= len_c;
                cnt_q <= '0; status_q <= '0; dev_cnt_q <= '0; dev_seen_q <= 1'b0;
            end
            if (state_q == S_DATA) begin
                dev_seen_q <= dev_seen_q | ~devsel_i;
                if (devsel_i && !dev_seen_q) dev_cnt_q <= dev_cnt_q + 3'd1;
                if (xfer) begin
                    cnt_q    <= cnt_q + 3'd1;
                    rem_q    <= rem_q - 3'd1;
                    wack_q   <= wr;
                    rvalid_q <= !wr;
                    if (!wr) rdata_q <= ad_io;
                end
                if (state_d == S_END) begin
                    done_q <= 1'b1; busy_q <= 1'b0; status_q <= st_end;
                end
            end
        end
    end
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_q <= 1'b1; frame_oe_q <= 1'b0; irdy_q <= 1'b1; irdy_oe_q <= 1'b0;
            ad_q <= '0; ad_oe_q <= 1'b0; cbe_q <= '0; cbe_oe_q <= 1'b0;
        end else begin
            frame_q <= frame_d; frame_oe_q <= frame_oe_d; irdy_q <= irdy_d; irdy_oe_q <= irdy_oe_d;
            ad_q <= ad_d; ad_oe_q <= ad_oe_d; cbe_q <= cbe_d; cbe_oe_q <= cbe_oe_d;
        end
    end
`ifdef PCI_INIT_PARITY_EN
    logic par_q, par_oe_q;
    // parity trails the AD/CBE it covers by one cycle
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= 1'b0; par_oe_q <= 1'b0;
        end else begin
            par_q <= ^ad_q ^ ^cbe_q; par_oe_q <= ad_oe_q;
        end
    end
    assign par_io = par_oe_q ? par_q : 1'bz;
`else
    assign par_io = 1'bz;
`endif
    assign frame_o       = frame_oe_q ? frame_q : 1'bz;
    assign irdy_o        = irdy_oe_q ? irdy_q : 1'bz;
    assign ad_io         = ad_oe_q ? ad_q : {32{1'bz}};
    assign cbe_o         = cbe_oe_q ? cbe_q : {4{1'bz}};
    assign wdata_ack_o   = wack_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign status_o      = status_q;
    assign xfer_cnt_o    = cnt_q;
endmodule

// File: tb/tb_pci_initiator.sv
// tb_pci_initiator: table-driven bench for pci_initiator with a behavioural PCI target at 0xFFFF0000.
// Idle FRAME/IRDY/PAR pull low and AD/CBE pull high, so a released pin reads as that level.
module tb_pci_initiator;
    typedef struct {
        logic [3:0]       cmd;
        logic [31:0]      addr;
        logic [2:0]       len;
        logic [3:0][31:0] wd;
        logic [1:0]       st;
        logic [2:0]       cnt;
        int               acks;
        int               rvs;
        logic [31:0]      rd0;
        logic [31:0]      rdl;
    } vec_t;
`ifdef PCI_INIT_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] cmd = '0, wbe = 4'hF;
    logic [31:0] addr = '0, wdata = '0;
    logic [2:0] len = '0;
    logic devsel = 1'b1, trdy = 1'b1, stop = 1'b1;
    wire wdata_ack, rdata_valid, busy, done, frame, irdy, par;
    wire [31:0] rdata, ad;
    wire [1:0] status;
    wire [2:0] xfer_cnt;
    wire [3:0] cbe;
    pulldown (frame);
    pulldown (irdy);
    pulldown (par);
    pullup (ad);
    pullup (cbe);
    int checks = 0, failures = 0, acks = 0, rvs = 0, dones = 0, widx = 0;
    logic [3:0][31:0] wq = '0;
    logic [31:0] rd [8];
    vec_t vt [9];
    pci_initiator dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cmd_i(cmd), .addr_i(addr), .len_i(len),
        .wdata_i(wdata), .wbe_i(wbe), .wdata_ack_o(wdata_ack), .rdata_o(rdata),
        .rdata_valid_o(rdata_valid), .busy_o(busy), .done_o(done), .status_o(status),
        .xfer_cnt_o(xfer_cnt), .frame_o(frame), .irdy_o(irdy), .ad_io(ad), .cbe_o(cbe),
        .par_io(par), .devsel_i(devsel), .trdy_i(trdy), .stop_i(stop)
    );
    always #5 clk = ~clk;
    // target: memory at FFFF00xx, addr bit 4 = disconnect on first word, CMD 0010 = retry
    logic [31:0] mem [8];
    logic [31:0] t_ad = '0;
    logic t_act = 1'b0, t_rd = 1'b0, t_retry = 1'b0, t_disc = 1'b0, t_ad_en = 1'b0;
    int t_idx = 0, t_wait = 0;
    assign ad = t_ad_en ? t_ad : {32{1'bz}};
    always @(posedge clk) begin
        if (!rst_n) t_act = 1'b0;
        else if (!t_act) begin
            if (frame === 1'b0 && irdy === 1'b1 && ad[31:16] == 16'hFFFF) begin
                t_act = 1'b1; t_rd = !cbe[0]; t_retry = cbe == 4'b0010; t_disc = ad[4];
                t_idx = int'(ad[3:2]); t_wait = t_rd ? 1 : 0;
            end
        end else if (irdy === 1'b0 && trdy == 1'b0) begin
            if (!t_rd) mem[t_idx] = ad;
            t_idx++;
            if (frame === 1'b1) t_act = 1'b0;
        end else if (frame === 1'b1 && irdy === 1'b1) t_act = 1'b0;
        #2;
        devsel = !t_act; stop = 1'b1; trdy = 1'b1; t_ad_en = 1'b0;
        if (t_act) begin
            if (t_retry) stop = 1'b0;
            else if (t_wait > 0) t_wait--;
            else begin
                trdy = 1'b0; stop = !t_disc; t_ad_en = t_rd; t_ad = mem[t_idx];
            end
        end
    end
    always @(posedge clk) begin
        #1;
        if (wdata_ack) begin
            widx++;
            wdata = (widx < 4) ? wq[widx[1:0]] : 32'h0;
        end
    end
    always @(negedge clk) begin
        if (wdata_ack) acks++;
        if (rdata_valid) begin
            if (rvs < 8) rd[rvs] = rdata;
            rvs++;
        end
        if (done) dones++;
    end
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask
    task automatic launch(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l);
        cmd = c; addr = a; len = l; acks = 0; rvs = 0; dones = 0; widx = 0; wdata = wq[0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic idle_bus(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_frame_z"}, frame, 0);
        chk({p, "_irdy_z"}, irdy, 0);
        chk({p, "_ad_z"}, ad, 32'hFFFF_FFFF);
        chk({p, "_cbe_z"}, cbe, 4'hF);
    endtask
    task automatic run_vec(input int i, input vec_t v);
        int lat;
        string p;
        p = $sformatf("v%0d", i);
        wq = v.wd;
        launch(v.cmd, v.addr, v.len);
        chk({p, "_busy_on"}, busy, 1);
        wait_done(lat);
        chk({p, "_done_seen"}, lat < 40, 1);
        if (v.st == 2'b11) chk({p, "_abort_latency_4to6"}, lat >= 4 && lat <= 6, 1);
        repeat (3) @(negedge clk);
        chk({p, "_status"}, status, v.st);
        chk({p, "_xfer_cnt"}, xfer_cnt, v.cnt);
        chk({p, "_wdata_acks"}, acks, v.acks);
        chk({p, "_rdata_valids"}, rvs, v.rvs);
        chk({p, "_done_pulses"}, dones, 1);
        idle_bus(p);
        if (v.rvs > 0) begin
            chk({p, "_rdata_first"}, rd[0], v.rd0);
            chk({p, "_rdata_last"}, rd[v.rvs - 1], v.rdl);
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int lat, k;
        vt[0] = '{4'b0111, 32'hFFFF0000, 3'd2, {32'h0, 32'h0, 32'h22222222, 32'h11111111}, 2'b00, 3'd2, 2, 0, 32'h0, 32'h0};
        vt[1] = '{4'b0110, 32'hFFFF0000, 3'd2, '0, 2'b00, 3'd2, 0, 2, 32'h11111111, 32'h22222222};
        vt[2] = '{4'b0111, 32'h12340000, 3'd1, {96'h0, 32'hDEADBEEF}, 2'b11, 3'd0, 0, 0, 32'h0, 32'h0};
        vt[3] = '{4'b0010, 32'hFFFF0000, 3'd1, '0, 2'b01, 3'd0, 0, 0, 32'h0, 32'h0};
        vt[4] = '{4'b0111, 32'hFFFF0008, 3'd0, {96'h0, 32'hAAAAAAAA}, 2'b00, 3'd1, 1, 0, 32'h0, 32'h0};
        vt[5] = '{4'b1111, 32'hFFFF0000, 3'd7, {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101}, 2'b00, 3'd4, 4, 0, 32'h0, 32'h0};
        vt[6] = '{4'b1100, 32'hFFFF0000, 3'd4, '0, 2'b00, 3'd4, 0, 4, 32'h01010101, 32'h04040404};
        vt[7] = '{4'b1110, 32'hFFFF0010, 3'd3, '0, 2'b10, 3'd1, 0, 1, 32'h01010101, 32'h01010101};
        vt[8] = '{4'b0110, 32'hFFFF0014, 3'd1, '0, 2'b00, 3'd1, 0, 1, 32'h02020202, 32'h02020202};
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_wdata_ack", wdata_ack, 0);
        chk("rst_par_z", par, 0);
        idle_bus("rst");
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);
        // read: address phase contents, then AD released during the target's wait state
        wq = '0;
        launch(4'b0110, 32'hFFFF0000, 3'd1);
        #1;
        chk("rdseq_addr_irdy", irdy, 1);
        chk("rdseq_addr_ad", ad, 32'hFFFF0000);
        chk("rdseq_addr_cbe", cbe, 4'b0110);
        @(negedge clk); #1;
        chk("rdseq_turnaround_ad", ad, 32'hFFFF_FFFF);
        chk("rdseq_data_irdy", irdy, 0);
        chk("rdseq_last_frame", frame, 1);
        wait_done(lat);
        repeat (3) @(negedge clk);
        chk("rdseq_status", status, 2'b00);
        chk("rdseq_rdata", rd[0], 32'h01010101);
        // parity trails address and write data by one cycle
        wq = {96'h0, 32'h00000001};
        launch(4'b0111, 32'hFFFF0000, 3'd1);
        @(negedge clk); #1;
        chk("par_addr", par, PAR_EN);
        @(negedge clk); #1;
        chk("par_wdata", par, PAR_EN);
        wait_done(lat);
        repeat (3) @(negedge clk);
        chk("parseq_status", status, 2'b00);
        chk("parseq_par_idle", par, 0);
        // reset in the second data phase of a 4-word write
        wq = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        launch(4'b0111, 32'hFFFF0000, 3'd4);
        k = 0;
        while (!wdata_ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rstseq_reached_phase2", k < 20, 1);
        #2 rst_n = 1'b0;
        #1;
        idle_bus("rstseq");
        chk("rstseq_status", status, 0);
        chk("rstseq_xfer_cnt", xfer_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstseq_no_done", dones, 0);
        run_vec(9, '{4'b0111, 32'hFFFF0004, 3'd1, {96'h0, 32'h5A5A5A5A}, 2'b00, 3'd1, 1, 0, 32'h0, 32'h0});
        chk("rstseq_mem_written", mem[1], 32'h5A5A5A5A);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
